// File: rtl/sync_fifo_param_if.sv
// Producer/consumer bundle for sync_fifo_param: write/read handshakes,
// data, fill status, programmable levels and sticky error flags.
interface sync_fifo_param_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024
) ();
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              wr_en;
    logic [DATA_W-1:0] din;
    logic              rd_en;
    logic [DATA_W-1:0] dout;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  af_level;
    logic [CNT_W-1:0]  ae_level;
    logic              almost_full;
    logic              almost_empty;
    logic              overflow;
    logic              underflow;
    logic              clr_err;

    modport master (
        output wr_en, din, rd_en, af_level, ae_level, clr_err,
        input  dout, rd_valid, full, empty, count,
               almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  wr_en, din, rd_en, af_level, ae_level, clr_err,
        output dout, rd_valid, full, empty, count,
               almost_full, almost_empty, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with exact fill count, programmable
// almost-full/almost-empty levels, sticky error flags and optional FWFT read.
module sync_fifo_param #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int FWFT   = 0,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input logic             clk,
    input logic             rst,
    sync_fifo_param_if.slave f
);
    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of two >= 4");
    end
    if (DATA_W < 1) begin : g_bad_width
        $error("sync_fifo_param: DATA_W must be >= 1");
    end

    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             rd_acc;
    logic             wr_acc;

    // A write into a full FIFO is only legal when a read frees a slot this cycle.
    always_comb begin
        rd_acc      = f.rd_en & ~empty_q;
        wr_acc      = f.wr_en & (~full_q | rd_acc);
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wr_acc) wptr_d = wptr_q + AW'(1);
        if (rd_acc) rptr_d = rptr_q + AW'(1);

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);

        // Set events take priority over a same-cycle clear.
        if (f.clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (f.wr_en & ~wr_acc) overflow_d  = 1'b1;
        if (f.rd_en & empty_q) underflow_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is not reset; a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) mem[wptr_q] <= f.din;
    end

    assign f.count        = count_q;
    assign f.full         = full_q;
    assign f.empty        = empty_q;
    assign f.overflow     = overflow_q;
    assign f.underflow    = underflow_q;
    assign f.almost_full  = (count_q >= f.af_level);
    assign f.almost_empty = (count_q <= f.ae_level);

    if (FWFT == 0) begin : g_std
        logic [DATA_W-1:0] dout_q, dout_d;
        logic              rd_valid_q, rd_valid_d;

        always_comb begin
            dout_d     = dout_q;
            rd_valid_d = rd_acc;
            if (rd_acc) dout_d = mem[rptr_q];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                dout_q     <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                dout_q     <= dout_d;
                rd_valid_q <= rd_valid_d;
            end
        end

        assign f.dout     = dout_q;
        assign f.rd_valid = rd_valid_q;
    end else begin : g_fwft
        // Head word is always presented; a pop exposes the next one a cycle later.
        assign f.dout     = mem[rptr_q];
        assign f.rd_valid = ~empty_q;
    end
endmodule

// File: tb/tb_sync_fifo_param.sv
// Drives a standard-read and an FWFT instance with identical stimulus and
// compares both against a queue-based reference model.
module tb_sync_fifo_param;
    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en, rd_en, clr_err;
    logic [DW-1:0] din;
    logic [CW-1:0] af_level, ae_level;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sync_fifo_param_if #(.DATA_W(DW), .DEPTH(DEPTH)) bs ();
    sync_fifo_param_if #(.DATA_W(DW), .DEPTH(DEPTH)) bf ();

    assign bs.wr_en = wr_en;  assign bf.wr_en = wr_en;
    assign bs.din = din;      assign bf.din = din;
    assign bs.rd_en = rd_en;  assign bf.rd_en = rd_en;
    assign bs.clr_err = clr_err;   assign bf.clr_err = clr_err;
    assign bs.af_level = af_level; assign bf.af_level = af_level;
    assign bs.ae_level = ae_level; assign bf.ae_level = ae_level;

    sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .f(bs));
    sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .FWFT(1)) u_fw (
        .clk(clk), .rst(rst), .f(bf));

    // Reference model: contents as a queue, flags from plain rules.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout;
    logic          m_valid, m_ov, m_uf;

    task automatic model_edge();
        bit rd_ok, wr_ok, ov_set, uf_set;
        if (rst) begin
            q.delete();
            m_ov = 0; m_uf = 0; m_dout = '0; m_valid = 0;
            return;
        end
        rd_ok  = rd_en && q.size() > 0;
        wr_ok  = wr_en && (q.size() < DEPTH || rd_ok);
        ov_set = wr_en && !wr_ok;
        uf_set = rd_en && q.size() == 0;
        m_valid = rd_ok;
        if (rd_ok) m_dout = q.pop_front();
        if (wr_ok) q.push_back(din);
        if (clr_err) begin m_ov = 0; m_uf = 0; end
        if (ov_set) m_ov = 1;
        if (uf_set) m_uf = 1;
    endtask

    function automatic logic [CW-1:0] ecnt();
        return CW'(q.size());
    endfunction

    // {full, empty, almost_full, almost_empty, overflow, underflow}
    function automatic logic [5:0] eflags();
        return {q.size() == DEPTH, q.size() == 0, q.size() >= int'(af_level),
                q.size() <= int'(ae_level), m_ov, m_uf};
    endfunction

    task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
        wr_en = w; din = d; rd_en = r; clr_err = c;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(1'b1, 16'h1111, 1'b1, 1'b0);
        total++; if (bs.count !== '0 || bf.count !== '0) begin bad++; $display("FAIL reset_count act=%0d/%0d exp=0", bs.count, bf.count); end
        total++; if ({bs.full, bs.empty, bs.overflow, bs.underflow} !== 4'b0100) begin bad++; $display("FAIL reset_flags act=%b exp=0100", {bs.full, bs.empty, bs.overflow, bs.underflow}); end
        total++; if (bs.rd_valid !== 1'b0 || bs.dout !== '0 || bf.rd_valid !== 1'b0) begin bad++; $display("FAIL reset_read act=%b/%h/%b exp=0/0000/0", bs.rd_valid, bs.dout, bf.rd_valid); end
        rst = 1'b0;
    endtask

    task automatic test_fill_drain();
        af_level = CW'(6); ae_level = CW'(2);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, DW'(i), 1'b0, 1'b0);
            total++; if (bs.count !== ecnt() || bf.count !== ecnt()) begin bad++; $display("FAIL fill_count act=%0d/%0d exp=%0d", bs.count, bf.count, ecnt()); end
            total++; if ({bs.full, bs.empty, bs.almost_full, bs.almost_empty, bs.overflow, bs.underflow} !== eflags()) begin bad++; $display("FAIL fill_flags act=%b exp=%b", {bs.full, bs.empty, bs.almost_full, bs.almost_empty, bs.overflow, bs.underflow}, eflags()); end
            total++; if (bf.dout !== 16'h0000 || bf.rd_valid !== 1'b1) begin bad++; $display("FAIL fill_fwft_head act=%h/%b exp=0000/1", bf.dout, bf.rd_valid); end
        end
        total++; if (bs.full !== 1'b1 || bs.count !== CW'(DEPTH)) begin bad++; $display("FAIL fill_full act=%b/%0d exp=1/%0d", bs.full, bs.count, DEPTH); end
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            total++; if (bs.rd_valid !== 1'b1 || bs.dout !== DW'(i)) begin bad++; $display("FAIL drain_data act=%b/%h exp=1/%h", bs.rd_valid, bs.dout, DW'(i)); end
            total++; if ({bf.full, bf.empty, bf.almost_full, bf.almost_empty, bf.overflow, bf.underflow} !== eflags()) begin bad++; $display("FAIL drain_flags act=%b exp=%b", {bf.full, bf.empty, bf.almost_full, bf.almost_empty, bf.overflow, bf.underflow}, eflags()); end
        end
        step(1'b0, '0, 1'b0, 1'b0);
        total++; if (bs.empty !== 1'b1 || bs.rd_valid !== 1'b0 || bs.dout !== DW'(DEPTH - 1)) begin bad++; $display("FAIL drain_end act=%b/%b/%h exp=1/0/%h", bs.empty, bs.rd_valid, bs.dout, DW'(DEPTH - 1)); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(16'h100 + i), 1'b0, 1'b0);
        step(1'b1, 16'hDEAD, 1'b0, 1'b0);
        total++; if (bs.overflow !== 1'b1 || bf.overflow !== 1'b1 || bs.count !== CW'(DEPTH)) begin bad++; $display("FAIL ovf_set act=%b/%b/%0d exp=1/1/%0d", bs.overflow, bf.overflow, bs.count, DEPTH); end
        step(1'b0, '0, 1'b0, 1'b1);
        total++; if (bs.overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear act=%b exp=0", bs.overflow); end
        step(1'b1, 16'hBEEF, 1'b0, 1'b1);
        total++; if (bs.overflow !== 1'b1 || bf.overflow !== 1'b1) begin bad++; $display("FAIL ovf_set_wins act=%b/%b exp=1/1", bs.overflow, bf.overflow); end
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            total++; if (bs.dout !== DW'(16'h100 + i) || bs.dout !== m_dout) begin bad++; $display("FAIL ovf_nolose act=%h exp=%h", bs.dout, DW'(16'h100 + i)); end
        end
    endtask

    task automatic test_underflow();
        step(1'b0, '0, 1'b1, 1'b0);
        total++; if (bs.underflow !== 1'b1 || bf.underflow !== 1'b1 || bs.rd_valid !== 1'b0) begin bad++; $display("FAIL udf_set act=%b/%b/%b exp=1/1/0", bs.underflow, bf.underflow, bs.rd_valid); end
        step(1'b0, '0, 1'b0, 1'b1);
        total++; if (bs.underflow !== 1'b0) begin bad++; $display("FAIL udf_clear act=%b exp=0", bs.underflow); end
        step(1'b1, 16'h1234, 1'b1, 1'b0);
        total++; if (bs.count !== CW'(1) || bs.underflow !== 1'b1 || bs.rd_valid !== 1'b0) begin bad++; $display("FAIL udf_rw_empty act=%0d/%b/%b exp=1/1/0", bs.count, bs.underflow, bs.rd_valid); end
        total++; if (bf.dout !== 16'h1234 || bf.rd_valid !== 1'b1) begin bad++; $display("FAIL udf_rw_fwft act=%h/%b exp=1234/1", bf.dout, bf.rd_valid); end
        step(1'b0, '0, 1'b1, 1'b1);
        total++; if (bs.dout !== 16'h1234 || bs.empty !== 1'b1 || bs.underflow !== 1'b0) begin bad++; $display("FAIL udf_pop act=%h/%b/%b exp=1234/1/0", bs.dout, bs.empty, bs.underflow); end
    endtask

    task automatic test_full_rw();
        for (int i = 0; i < DEPTH; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < DEPTH + 3; i++) begin
            step(1'b1, DW'($urandom), 1'b1, 1'b0);
            total++; if (bs.count !== CW'(DEPTH) || bs.full !== 1'b1 || bs.overflow !== 1'b0) begin bad++; $display("FAIL frw_state act=%0d/%b/%b exp=%0d/1/0", bs.count, bs.full, bs.overflow, DEPTH); end
            total++; if (bs.rd_valid !== 1'b1 || bs.dout !== m_dout) begin bad++; $display("FAIL frw_data act=%b/%h exp=1/%h", bs.rd_valid, bs.dout, m_dout); end
            total++; if (bf.dout !== q[0]) begin bad++; $display("FAIL frw_fwft act=%h exp=%h", bf.dout, q[0]); end
        end
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            total++; if (bs.dout !== m_dout) begin bad++; $display("FAIL frw_drain act=%h exp=%h", bs.dout, m_dout); end
        end
    endtask

    task automatic test_fwft();
        step(1'b1, 16'h00A5, 1'b0, 1'b0);
        total++; if (bf.dout !== 16'h00A5 || bf.rd_valid !== 1'b1) begin bad++; $display("FAIL fwft_show act=%h/%b exp=00a5/1", bf.dout, bf.rd_valid); end
        step(1'b0, '0, 1'b1, 1'b0);
        total++; if (bf.empty !== 1'b1 || bf.rd_valid !== 1'b0) begin bad++; $display("FAIL fwft_pop act=%b/%b exp=1/0", bf.empty, bf.rd_valid); end
    endtask

    task automatic test_levels();
        af_level = CW'(4); ae_level = CW'(1);
        for (int n = 0; n <= 5; n++) begin
            total++; if (bs.almost_empty !== (n <= 1) || bs.almost_full !== (n >= 4) || bf.almost_full !== (n >= 4)) begin bad++; $display("FAIL levels n=%0d act=ae%b af%b exp=ae%b af%b", n, bs.almost_empty, bs.almost_full, n <= 1, n >= 4); end
            step(1'b1, DW'(n), 1'b0, 1'b0);
        end
        rst = 1'b1;
        step(1'b1, 16'h7777, 1'b1, 1'b0);
        rst = 1'b0;
        total++; if (bs.count !== '0 || bs.empty !== 1'b1 || bf.count !== '0 || bf.empty !== 1'b1) begin bad++; $display("FAIL levels_rst act=%0d/%b exp=0/1", bs.count, bs.empty); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                af_level = CW'($urandom_range(1, DEPTH));
                ae_level = CW'($urandom_range(0, DEPTH - 1));
            end
            step(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 15) == 0));
            total++; if (bs.count !== ecnt() || bf.count !== ecnt()) begin bad++; $display("FAIL rnd_count i=%0d act=%0d/%0d exp=%0d", i, bs.count, bf.count, ecnt()); end
            total++; if ({bs.full, bs.empty, bs.almost_full, bs.almost_empty, bs.overflow, bs.underflow} !== eflags() ||
                         {bf.full, bf.empty, bf.almost_full, bf.almost_empty, bf.overflow, bf.underflow} !== eflags()) begin
                bad++; $display("FAIL rnd_flags i=%0d act=%b/%b exp=%b", i, {bs.full, bs.empty, bs.almost_full, bs.almost_empty, bs.overflow, bs.underflow}, {bf.full, bf.empty, bf.almost_full, bf.almost_empty, bf.overflow, bf.underflow}, eflags()); end
            total++; if (bs.rd_valid !== m_valid || bs.dout !== m_dout) begin bad++; $display("FAIL rnd_std i=%0d act=%b/%h exp=%b/%h", i, bs.rd_valid, bs.dout, m_valid, m_dout); end
            total++; if (bf.rd_valid !== (q.size() > 0) || (q.size() > 0 && bf.dout !== q[0])) begin bad++; $display("FAIL rnd_fwft i=%0d act=%b/%h exp=%b", i, bf.rd_valid, bf.dout, q.size() > 0); end
        end
    endtask

    initial begin
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; din = '0;
        af_level = CW'(DEPTH); ae_level = '0;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow();
        test_full_rw();
        test_fwft();
        test_levels();
        test_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
